// File: rtl/dm_pkg.sv
// dm_pkg: shared debug-module types and constants (SBA state, sbcs fields, sberror codes).
`default_nettype none

package dm_pkg;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Read      = 3'd1,
        Write     = 3'd2,
        WaitRead  = 3'd3,
        WaitWrite = 3'd4
    } sba_state_e;

    typedef struct packed {
        logic       sbreadonaddr;
        logic [2:0] sbaccess;
        logic       sbautoincrement;
        logic       sbreadondata;
    } sbcs_t;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrBadAddr = 3'd2;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: System Bus Access master FSM between the DM CSRs and the SoC bus.
// Optional misalignment error reporting is enabled with `define DM_SBA_ALIGN_CHECK_EN.
`default_nettype none

module dm_sba_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter bit          ReadByteEnable = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);

    localparam int unsigned NumBytes  = BusWidth / 8;
    localparam int unsigned OffW      = $clog2(NumBytes);
    localparam logic [2:0]  MaxAccess = 3'(OffW);

    function automatic logic [NumBytes-1:0] lane_be(input logic [OffW-1:0] off,
                                                    input logic [2:0]      access);
        logic [NumBytes-1:0] mask;
        mask = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if (i < (1 << access)) mask[i] = 1'b1;
        end
        // Bytes shifted past the top lane are dropped, not wrapped.
        return mask << off;
    endfunction

    function automatic logic [BusWidth-1:0] lane_wdata(input logic [BusWidth-1:0] data,
                                                       input logic [OffW-1:0]     off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [BusWidth-1:0] lane_rdata(input logic [BusWidth-1:0] rdata,
                                                       input logic [OffW-1:0]     off,
                                                       input logic [2:0]          access);
        logic [BusWidth-1:0] shifted;
        logic [BusWidth-1:0] res;
        shifted = rdata >> {off, 3'b000};
        res     = '0;
        for (int i = 0; i < NumBytes; i++) begin
            if (i < (1 << access)) res[8*i +: 8] = shifted[8*i +: 8];
        end
        return res;
    endfunction

    sbcs_t               sbcs;
    sba_state_e          state;
    logic [BusWidth-1:0] address;
    logic [2:0]          access_q;
    logic                aborted;

    logic                ev_read;
    logic                ev_write;
    logic [BusWidth-1:0] req_addr;
    logic [OffW-1:0]     req_off;
    logic [2:0]          req_err;
`ifdef DM_SBA_ALIGN_CHECK_EN
    logic [BusWidth-1:0] size_mask;
`endif

    assign sbcs = '{sbreadonaddr:    sbreadonaddr_i,
                    sbaccess:        sbaccess_i,
                    sbautoincrement: sbautoincrement_i,
                    sbreadondata:    sbreadondata_i};

    assign sbaddress_o = address;
    assign sbbusy_o    = (state != Idle);

    // Event arbitration; an address write in the same cycle supplies the request address.
    always_comb begin
        ev_read  = 1'b0;
        ev_write = 1'b0;
        if (sbaddress_write_valid_i && sbcs.sbreadonaddr) begin
            ev_read = 1'b1;
        end else if (sbdata_write_valid_i) begin
            ev_write = 1'b1;
        end else if (sbdata_read_valid_i && sbcs.sbreadondata) begin
            ev_read = 1'b1;
        end
        req_addr = sbaddress_write_valid_i ? sbaddress_i : address;
        req_off  = req_addr[OffW-1:0];
        req_err  = SbErrNone;
`ifdef DM_SBA_ALIGN_CHECK_EN
        size_mask = BusWidth'((1 << sbcs.sbaccess) - 1);
`endif
        if (sbcs.sbaccess > MaxAccess) begin
            req_err = SbErrSize;
        end
`ifdef DM_SBA_ALIGN_CHECK_EN
        else if ((req_addr & size_mask) != '0) begin
            req_err = SbErrAlign;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= Idle;
            address         <= '0;
            access_q        <= '0;
            aborted         <= 1'b0;
            sbdata_o        <= '0;
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= SbErrNone;
            master_req_o    <= 1'b0;
            master_we_o     <= 1'b0;
            master_add_o    <= '0;
            master_wdata_o  <= '0;
            master_be_o     <= '0;
        end else begin
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            unique case (state)
                Idle: begin
                    if (dmactive_i) begin
                        if (sbaddress_write_valid_i) address <= sbaddress_i;
                        if (ev_read || ev_write) begin
                            if (req_err != SbErrNone) begin
                                sberror_valid_o <= 1'b1;
                                sberror_o       <= req_err;
                            end else begin
                                state          <= ev_write ? Write : Read;
                                access_q       <= sbcs.sbaccess;
                                master_req_o   <= 1'b1;
                                master_we_o    <= ev_write;
                                master_add_o   <= req_addr;
                                master_wdata_o <= ev_write ? lane_wdata(sbdata_i, req_off) : '0;
                                master_be_o    <= (ev_write || ReadByteEnable)
                                                  ? lane_be(req_off, sbcs.sbaccess) : '1;
                            end
                        end
                    end
                end
                Read, Write: begin
                    if (!dmactive_i) begin
                        master_req_o <= 1'b0;
                        state        <= Idle;
                    end else if (master_gnt_i) begin
                        master_req_o <= 1'b0;
                        state        <= (state == Read) ? WaitRead : WaitWrite;
                    end
                end
                WaitRead, WaitWrite: begin
                    if (master_r_valid_i) begin
                        state   <= Idle;
                        aborted <= 1'b0;
                        // A response to an access aborted by dmactive is swallowed.
                        if (dmactive_i && !aborted) begin
                            if (master_r_err_i) begin
                                sberror_valid_o <= 1'b1;
                                sberror_o       <= SbErrBadAddr;
                            end else begin
                                if (state == WaitRead) begin
                                    sbdata_o       <= lane_rdata(master_r_rdata_i,
                                                                 master_add_o[OffW-1:0], access_q);
                                    sbdata_valid_o <= 1'b1;
                                end
                                if (sbcs.sbautoincrement) begin
                                    address <= address + (BusWidth'(1) << access_q);
                                end
                            end
                        end
                    end else if (!dmactive_i) begin
                        aborted <= 1'b1;
                    end
                end
                default: state <= Idle;
            endcase
            if (!dmactive_i) address <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_sba_ctrl.sv
// tb_dm_sba_ctrl: randomized and directed bench for dm_sba_ctrl with a byte-level reference model.
`default_nettype none

module tb_dm_sba_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmactive;
    logic [31:0] sbaddress;
    logic        sbaddress_write_valid;
    logic        sbreadonaddr;
    logic        sbautoincrement;
    logic [2:0]  sbaccess;
    logic        sbreadondata;
    logic [31:0] sbdata;
    logic        sbdata_read_valid;
    logic        sbdata_write_valid;
    logic [31:0] sbaddress_out;
    logic [31:0] sbdata_out;
    logic        sbdata_valid;
    logic        sbbusy;
    logic        sberror_valid;
    logic [2:0]  sberror;
    logic        req;
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_valid;
    logic        r_err;
    logic [31:0] rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_addr   = 32'h0;

    dm_sba_ctrl #(.BusWidth(32), .ReadByteEnable(1'b1)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .dmactive_i              (dmactive),
        .sbaddress_i             (sbaddress),
        .sbaddress_write_valid_i (sbaddress_write_valid),
        .sbreadonaddr_i          (sbreadonaddr),
        .sbautoincrement_i       (sbautoincrement),
        .sbaccess_i              (sbaccess),
        .sbreadondata_i          (sbreadondata),
        .sbdata_i                (sbdata),
        .sbdata_read_valid_i     (sbdata_read_valid),
        .sbdata_write_valid_i    (sbdata_write_valid),
        .sbaddress_o             (sbaddress_out),
        .sbdata_o                (sbdata_out),
        .sbdata_valid_o          (sbdata_valid),
        .sbbusy_o                (sbbusy),
        .sberror_valid_o         (sberror_valid),
        .sberror_o               (sberror),
        .master_req_o            (req),
        .master_we_o             (we),
        .master_add_o            (add),
        .master_wdata_o          (wdata),
        .master_be_o             (be),
        .master_gnt_i            (gnt),
        .master_r_valid_i        (r_valid),
        .master_r_err_i          (r_err),
        .master_r_rdata_i        (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte b of the bus carries byte (b - off) of the access, if inside the lane.
    function automatic logic [3:0] model_be(input int off, input int size);
        logic [3:0] r = '0;
        for (int b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + size);
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int off);
        logic [31:0] r = '0;
        for (int b = 0; b < 4; b++) if (b >= off) r[8*b +: 8] = d[8*(b-off) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] d, input int off, input int size);
        logic [31:0] r = '0;
        for (int k = 0; k < size; k++) if (off + k < 4) r[8*k +: 8] = d[8*(off+k) +: 8];
        return r;
    endfunction

    task automatic clear_events();
        sbaddress_write_valid = 1'b0;
        sbdata_write_valid    = 1'b0;
        sbdata_read_valid     = 1'b0;
    endtask

    // kind: 0 read-on-address, 1 data write, 2 read-on-data.
    task automatic run_txn(input int kind, input bit load_addr, input logic [31:0] addr,
                           input logic [2:0] acc, input bit autoinc, input logic [31:0] data,
                           input bit err, input int gdly, input int rlat, input logic [31:0] rd);
        int          size;
        int          off;
        logic [2:0]  code;
        logic [31:0] held_add;
        if (kind != 0 && load_addr) begin
            sbreadonaddr          = 1'b0;
            sbaddress             = addr;
            sbaddress_write_valid = 1'b1;
            @(negedge clk);
            clear_events();
            m_addr = addr;
        end
        if (kind == 0) m_addr = addr;
        sbaccess        = acc;
        sbautoincrement = autoinc;
        sbdata          = data;
        sbreadonaddr    = (kind == 0);
        sbreadondata    = (kind == 2);
        case (kind)
            0: begin sbaddress = addr; sbaddress_write_valid = 1'b1; end
            1: sbdata_write_valid = 1'b1;
            default: sbdata_read_valid = 1'b1;
        endcase
        size = 1 << acc;
        off  = int'(m_addr[1:0]);
        code = 3'd0;
        if (acc > 3'd2) code = 3'd4;
`ifdef DM_SBA_ALIGN_CHECK_EN
        else if ((m_addr % size) != 0) code = 3'd3;
`endif
        @(negedge clk);
        clear_events();
        if (code != 3'd0) begin
            check("err_valid", sberror_valid, 1'b1);
            check("err_code", sberror, code);
            check("err_no_req", req, 1'b0);
            check("err_busy", sbbusy, 1'b0);
            check("err_addr", sbaddress_out, m_addr);
            return;
        end
        check("req", req, 1'b1);
        check("we", we, kind == 1);
        check("add", add, m_addr);
        check("be", be, model_be(off, size));
        if (kind == 1) check("wdata", wdata, model_wdata(data, off));
        held_add = m_addr;
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            check("req_hold", req, 1'b1);
            check("add_hold", add, held_add);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        check("req_drop", req, 1'b0);
        check("busy_wait", sbbusy, 1'b1);
        for (int i = 0; i < rlat; i++) @(negedge clk);
        rdata   = rd;
        r_err   = err;
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        r_err   = 1'b0;
        check("busy_done", sbbusy, 1'b0);
        if (err) begin
            check("buserr_valid", sberror_valid, 1'b1);
            check("buserr_code", sberror, 3'd2);
            check("buserr_nodata", sbdata_valid, 1'b0);
        end else begin
            check("no_err", sberror_valid, 1'b0);
            check("data_valid", sbdata_valid, kind != 1);
            if (kind != 1) check("rdata", sbdata_out, model_rdata(rd, off, size));
            if (autoinc) m_addr = m_addr + size;
        end
        check("addr_after", sbaddress_out, m_addr);
        @(negedge clk);
        check("pulse_end", {sbdata_valid, sberror_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dmactive = 1'b1; sbaddress = '0; sbreadonaddr = 1'b0;
        sbautoincrement = 1'b0; sbaccess = 3'd2; sbreadondata = 1'b0; sbdata = '0;
        gnt = 1'b0; r_valid = 1'b0; r_err = 1'b0; rdata = '0;
        clear_events();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_outputs", {sbaddress_out, sbdata_out, sbdata_valid, sbbusy, sberror_valid, sberror},
              '0);
        check("rst_master", {req, we, add, wdata, be}, '0);

        // Read on address write.
        run_txn(0, 1'b0, 32'h1000, 3'd2, 1'b0, 32'h0, 1'b0, 1, 0, 32'hDEADBEEF);
        check("dir_read_data", sbdata_out, 32'hDEADBEEF);
        check("dir_read_addr", sbaddress_out, 32'h1000);
        // Auto-incremented byte writes.
        run_txn(1, 1'b1, 32'h2001, 3'd0, 1'b1, 32'hA5, 1'b0, 0, 1, 32'h0);
        run_txn(1, 1'b0, 32'h0, 3'd0, 1'b1, 32'hA5, 1'b0, 2, 0, 32'h0);
        check("dir_autoinc_addr", sbaddress_out, 32'h2003);
        // Bad size, bus error, misaligned word.
        run_txn(0, 1'b0, 32'h3000, 3'd3, 1'b0, 32'h0, 1'b0, 0, 0, 32'h0);
        run_txn(0, 1'b0, 32'h4000, 3'd2, 1'b1, 32'h0, 1'b1, 0, 0, 32'h12345678);
        run_txn(0, 1'b0, 32'h1002, 3'd2, 1'b0, 32'h0, 1'b0, 0, 0, 32'hCAFEF00D);

        // Abort while waiting for grant.
        sbaccess = 3'd2; sbreadonaddr = 1'b1; sbaddress = 32'h5000; sbaddress_write_valid = 1'b1;
        @(negedge clk);
        clear_events();
        check("abort_req", req, 1'b1);
        dmactive = 1'b0;
        @(negedge clk);
        check("abort_req_drop", req, 1'b0);
        check("abort_busy", sbbusy, 1'b0);
        check("abort_addr", sbaddress_out, 32'h0);
        dmactive = 1'b1;

        // Abort after grant: response discarded.
        sbaddress = 32'h6000; sbaddress_write_valid = 1'b1;
        @(negedge clk);
        clear_events();
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        dmactive = 1'b0;
        @(negedge clk);
        check("wabort_busy", sbbusy, 1'b1);
        rdata = 32'h11111111; r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        check("wabort_idle", sbbusy, 1'b0);
        check("wabort_pulses", {sbdata_valid, sberror_valid}, 2'b00);
        check("wabort_addr", sbaddress_out, 32'h0);
        dmactive = 1'b1;

        // Events while busy are ignored.
        sbautoincrement = 1'b0; sbaddress = 32'h7000; sbaddress_write_valid = 1'b1;
        @(negedge clk);
        clear_events();
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        sbaddress = 32'h7777; sbaddress_write_valid = 1'b1; sbdata_write_valid = 1'b1;
        @(negedge clk);
        clear_events();
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        @(negedge clk);
        check("busy_ignore_req", req, 1'b0);
        check("busy_ignore_addr", sbaddress_out, 32'h7000);
        m_addr = 32'h7000;

        for (int n = 0; n < 60; n++) begin
            logic [2:0] acc;
            acc = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            run_txn(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, acc,
                    1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
